inv_sub_bytes_unit: RTL and testbench

//  Sequential AES InvSubBytes engine for the decryption datapath.
//  - Accepts a 128-bit state and applies the inverse S-box to all 16 bytes.
//  - Processes LANES bytes per clock, reusing one LANES-wide inverse S-box.
//  - Returns the result over a valid/ready handshake.
//  - Sits between InvShiftRows and AddRoundKey in the inverse round loop.

---
 rtl/inv_sub_bytes_unit.sv | 137 +++++++++++++
 tb/tb_inv_sub_bytes_unit.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_unit.sv
// Sequential AES InvSubBytes engine: substitutes LANES bytes per clock through
// one shared combinational inverse S-box and returns the block on valid/ready.
module inv_sub_bytes_unit #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int unsigned N        = 16 / LANES;
  localparam int unsigned CNT_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [15:0][7:0]    work_q;
  logic [15:0][7:0]    work_d;
  logic [127:0]        out_state_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                busy_q;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // Inverse S-box: inverse affine of (x ^ 0x63), then field inverse.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] t;
    logic [7:0] y;
    t = x ^ 8'h63;
    y = 8'h00;
    for (int i = 0; i < 8; i++) begin
      y[i] = t[(i + 2) % 8] ^ t[(i + 5) % 8] ^ t[(i + 7) % 8];
    end
    return gf_inv(y);
  endfunction

  // Substitute the chunk selected by cnt_q; byte k lives at packed index 15-k.
  always_comb begin
    work_d = work_q;
    for (int unsigned l = 0; l < LANES; l++) begin
      work_d[4'(15 - (32'(cnt_q) * LANES + l))] =
        inv_sbox(work_q[4'(15 - (32'(cnt_q) * LANES + l))]);
    end
  end

  // Control FSM with registered handshake outputs and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      out_state_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            work_q     <= in_state;
            cnt_q      <= '0;
            state_q    <= SUB;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        SUB: begin
          work_q <= work_d;
          if (cnt_q == CNT_LAST) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_state_q <= work_d;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_valid_q && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = out_state_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_inv_sub_bytes_unit.sv
// Directed self-checking bench for inv_sub_bytes_unit (LANES = 4, 1 and 16).
module tb_inv_sub_bytes_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_state;

  logic         in_ready4, out_valid4, busy4;
  logic [127:0] out_state4;
  logic         in_ready1, out_valid1, busy1;
  logic [127:0] out_state1;
  logic         in_ready16, out_valid16, busy16;
  logic [127:0] out_state16;

  int checks = 0;
  int errors = 0;

  logic [7:0] fwd [256];

  localparam logic [127:0] VEC_A = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] EXP_A = 128'h000102030405060708090a0b0c0d0e0f;

  always #5 clk = ~clk;

  inv_sub_bytes_unit #(.LANES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_state(in_state), .out_valid(out_valid4), .out_ready(out_ready),
    .out_state(out_state4), .busy(busy4));

  inv_sub_bytes_unit #(.LANES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_state(in_state), .out_valid(out_valid1), .out_ready(out_ready),
    .out_state(out_state1), .busy(busy1));

  inv_sub_bytes_unit #(.LANES(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
    .in_state(in_state), .out_valid(out_valid16), .out_ready(out_ready),
    .out_state(out_state16), .busy(busy16));

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box by brute-force inverse search plus forward affine map.
  function automatic logic [7:0] ref_fwd_sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    inv = 8'h00;
    if (x != 8'h00) begin
      for (int y = 1; y < 256; y++) begin
        if (ref_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
      end
    end
    c = 8'h63;
    for (int i = 0; i < 8; i++) begin
      s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
             ^ inv[(i + 7) % 8] ^ c[i];
    end
    return s;
  endfunction

  function automatic logic [127:0] rep16(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] v);
    in_state = v;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid4(output int lat);
    lat = 0;
    while (!out_valid4 && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic pulse_ready();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got rdy=%b vld=%b busy=%b want 1 0 0", in_ready4, out_valid4, busy4);
    end
    checks++;
    if (out_state4 !== 128'h0 || out_state1 !== 128'h0 || out_state16 !== 128'h0) begin
      errors++;
      $display("FAIL reset_out_state got %h want 0", out_state4);
    end
  endtask

  task automatic test_basic();
    int lat;
    send(VEC_A);
    wait_valid4(lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL basic_latency got %0d want 4", lat);
    end
    checks++;
    if (out_state4 !== EXP_A) begin
      errors++;
      $display("FAIL basic_data got %h want %h", out_state4, EXP_A);
    end
    checks++;
    if (busy4 !== 1'b1 || in_ready4 !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_flags got busy=%b rdy=%b want 1 0", busy4, in_ready4);
    end
    pulse_ready();
    checks++;
    if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle got vld=%b rdy=%b busy=%b want 0 1 0", out_valid4, in_ready4, busy4);
    end
    checks++;
    if (out_state4 !== EXP_A) begin
      errors++;
      $display("FAIL basic_hold got %h want %h", out_state4, EXP_A);
    end
  endtask

  task automatic test_constant();
    logic [7:0] ins  [3];
    logic [7:0] exps [3];
    int lat;
    ins[0] = 8'h52; exps[0] = 8'h48;
    ins[1] = 8'h16; exps[1] = 8'hff;
    ins[2] = 8'h01; exps[2] = 8'h09;
    for (int i = 0; i < 3; i++) begin
      send(rep16(ins[i]));
      wait_valid4(lat);
      checks++;
      if (out_valid4 !== 1'b1 || out_state4 !== rep16(exps[i])) begin
        errors++;
        $display("FAIL constant_%0d got vld=%b %h want %h", i, out_valid4, out_state4, rep16(exps[i]));
      end
      pulse_ready();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit bad;
    send(rep16(8'h52));
    wait_valid4(lat);
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid4 !== 1'b1 || out_state4 !== rep16(8'h48) || in_ready4 !== 1'b0 || busy4 !== 1'b1)
        bad = 1'b1;
      step();
    end
    checks++;
    if (bad || out_valid4 !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_hold got vld=%b rdy=%b busy=%b %h want 1 0 1 %h",
               out_valid4, in_ready4, busy4, out_state4, rep16(8'h48));
    end
    pulse_ready();
    checks++;
    if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release got vld=%b rdy=%b busy=%b want 0 1 0", out_valid4, in_ready4, busy4);
    end
  endtask

  task automatic test_reset_midop();
    int lat;
    bit seen;
    send(VEC_A);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || busy4 !== 1'b0 || out_state4 !== 128'h0) begin
      errors++;
      $display("FAIL midop_reset got vld=%b rdy=%b busy=%b %h want 0 1 0 0",
               out_valid4, in_ready4, busy4, out_state4);
    end
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid4 !== 1'b0) seen = 1'b1;
      step();
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midop_no_valid got 1 want 0");
    end
    send(128'h0);
    wait_valid4(lat);
    checks++;
    if (lat !== 4 || out_state4 !== rep16(8'h52)) begin
      errors++;
      $display("FAIL midop_new_block got lat=%0d %h want 4 %h", lat, out_state4, rep16(8'h52));
    end
    pulse_ready();
  endtask

  task automatic test_ignore_busy();
    int lat;
    bit seen;
    send(VEC_A);
    step();
    in_state = rep16(8'h52);
    in_valid = 1'b1;
    step();
    checks++;
    if (in_ready4 !== 1'b0 || busy4 !== 1'b1) begin
      errors++;
      $display("FAIL ignore_flags got rdy=%b busy=%b want 0 1", in_ready4, busy4);
    end
    wait_valid4(lat);
    step();
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid4 !== 1'b1 || out_state4 !== EXP_A) begin
      errors++;
      $display("FAIL ignore_data got vld=%b %h want 1 %h", out_valid4, out_state4, EXP_A);
    end
    pulse_ready();
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) seen = 1'b1;
      step();
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL ignore_single_output got extra activity want idle");
    end
  endtask

  task automatic test_round_trip();
    logic [127:0] plain;
    logic [127:0] cipher;
    int l4, l1, l16;
    do_reset();
    for (int blk = 0; blk < 64; blk++) begin
      for (int k = 0; k < 16; k++) begin
        plain[8*(15-k) +: 8]  = 8'(blk * 4 + k);
        cipher[8*(15-k) +: 8] = fwd[8'(blk * 4 + k)];
      end
      send(cipher);
      l4 = 0; l1 = 0; l16 = 0;
      for (int c = 1; c <= 40; c++) begin
        step();
        if (out_valid4 && l4 == 0) l4 = c;
        if (out_valid1 && l1 == 0) l1 = c;
        if (out_valid16 && l16 == 0) l16 = c;
        if (l4 != 0 && l1 != 0 && l16 != 0) break;
      end
      checks++;
      if (l4 !== 4 || l1 !== 16 || l16 !== 1) begin
        errors++;
        $display("FAIL rt_latency blk %0d got %0d/%0d/%0d want 4/16/1", blk, l4, l1, l16);
      end
      checks++;
      if (out_state4 !== plain || out_state1 !== plain || out_state16 !== plain) begin
        errors++;
        $display("FAIL rt_data blk %0d got %h %h %h want %h", blk, out_state4, out_state1, out_state16, plain);
      end
      pulse_ready();
      checks++;
      if (in_ready4 !== 1'b1 || in_ready1 !== 1'b1 || in_ready16 !== 1'b1) begin
        errors++;
        $display("FAIL rt_idle blk %0d got %b%b%b want 111", blk, in_ready4, in_ready1, in_ready16);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_state  = 128'h0;
    for (int x = 0; x < 256; x++) fwd[x] = ref_fwd_sbox(8'(x));
    test_reset();
    test_basic();
    test_constant();
    test_backpressure();
    test_reset_midop();
    test_ignore_busy();
    test_round_trip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
